// File: rtl/px_mem_wr_arbiter.sv
// Round-robin write arbiter: two pixel producers share one burst-write port of the pixel memory.
// state | meaning: IDLE = no owner, arbitrate | REQ = command held until memory grant | XFER = forward owner's burst
module px_mem_wr_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqA_WR_REQ,
  input  logic [19:0] reqA_WR_Addr,
  input  logic [3:0]  reqA_WR_burst,
  input  logic        reqA_WR_VLD,
  input  logic [15:0] reqA_out,
  input  logic        reqB_WR_REQ,
  input  logic [19:0] reqB_WR_Addr,
  input  logic [3:0]  reqB_WR_burst,
  input  logic        reqB_WR_VLD,
  input  logic [15:0] reqB_out,
  output logic        reqA_WR_GRANT,
  output logic        reqA_WR_RDY,
  output logic        reqB_WR_GRANT,
  output logic        reqB_WR_RDY,
  output logic        pxMem_WR_REQ,
  output logic [19:0] pxMem_WR_Addr,
  output logic [3:0]  pxMem_WR_burst,
  output logic        pxMem_WR_VLD,
  output logic [15:0] pxMem_out,
  input  logic        pxMem_WR_GRANT,
  input  logic        pxMem_WR_RDY,
  output logic        wr_busy
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} stateT;

  stateT       state, stateNxt;
  logic        owner, lastOwner;
  logic [19:0] addrReg;
  logic [3:0]  burstReg;
  logic [3:0]  cnt;
  logic        winner, loadCmd, beat, ownerVld;
  logic [15:0] ownerData;

  // Ties go to whoever did not own the previous burst
  assign winner    = reqB_WR_REQ && (!reqA_WR_REQ || !lastOwner);
  assign ownerVld  = owner ? reqB_WR_VLD : reqA_WR_VLD;
  assign ownerData = owner ? reqB_out : reqA_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt       = state;
    loadCmd        = 1'b0;
    beat           = 1'b0;
    pxMem_WR_REQ   = 1'b0;
    pxMem_WR_VLD   = 1'b0;
    pxMem_out      = '0;
    pxMem_WR_Addr  = addrReg;
    pxMem_WR_burst = burstReg;
    reqA_WR_RDY    = 1'b0;
    reqB_WR_RDY    = 1'b0;
    wr_busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (reqA_WR_REQ || reqB_WR_REQ) begin
          loadCmd  = 1'b1;
          stateNxt = REQ;
        end
      end
      REQ: begin
        pxMem_WR_REQ = 1'b1;
        if (pxMem_WR_GRANT) stateNxt = XFER;
      end
      XFER: begin
        pxMem_WR_VLD = ownerVld;
        pxMem_out    = ownerData;
        reqA_WR_RDY  = !owner && pxMem_WR_RDY;
        reqB_WR_RDY  = owner && pxMem_WR_RDY;
        beat         = ownerVld && pxMem_WR_RDY;
        if (beat && cnt == 4'd0) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
    reqA_WR_GRANT = wr_busy && !owner;
    reqB_WR_GRANT = wr_busy && owner;
  end

  // cnt counts remaining beats down; the beat seen at zero is the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 1'b0;
      lastOwner <= 1'b1;
      addrReg   <= '0;
      burstReg  <= '0;
      cnt       <= '0;
    end else if (loadCmd) begin
      owner     <= winner;
      lastOwner <= winner;
      addrReg   <= winner ? reqB_WR_Addr : reqA_WR_Addr;
      burstReg  <= winner ? reqB_WR_burst : reqA_WR_burst;
      cnt       <= winner ? reqB_WR_burst : reqA_WR_burst;
    end else if (beat && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_px_mem_wr_arbiter.sv
// Directed bench for px_mem_wr_arbiter: producer models, a memory command responder and a write log.
module tb_px_mem_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqA_WR_REQ = 1'b0, reqB_WR_REQ = 1'b0;
  logic [19:0] reqA_WR_Addr = '0, reqB_WR_Addr = '0;
  logic [3:0]  reqA_WR_burst = '0, reqB_WR_burst = '0;
  logic        reqA_WR_VLD = 1'b0, reqB_WR_VLD = 1'b0;
  logic [15:0] reqA_out = '0, reqB_out = '0;
  logic        reqA_WR_GRANT, reqA_WR_RDY, reqB_WR_GRANT, reqB_WR_RDY;
  logic        pxMem_WR_REQ, pxMem_WR_VLD, wr_busy;
  logic [19:0] pxMem_WR_Addr;
  logic [3:0]  pxMem_WR_burst;
  logic [15:0] pxMem_out;
  logic        pxMem_WR_GRANT = 1'b0;
  logic        pxMem_WR_RDY = 1'b1;
  logic [46:0] allOuts;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;

  logic        aEn = 1'b0, bEn = 1'b0, aGap = 1'b0;
  logic [15:0] aBase = '0, bBase = '0;
  int          grantDelay = 1;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    logic        isB;
    int          cyc;
  } wrRecT;
  wrRecT writes[$];
  int    reqRise[$];

  px_mem_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .reqA_WR_REQ(reqA_WR_REQ), .reqA_WR_Addr(reqA_WR_Addr), .reqA_WR_burst(reqA_WR_burst),
    .reqA_WR_VLD(reqA_WR_VLD), .reqA_out(reqA_out),
    .reqB_WR_REQ(reqB_WR_REQ), .reqB_WR_Addr(reqB_WR_Addr), .reqB_WR_burst(reqB_WR_burst),
    .reqB_WR_VLD(reqB_WR_VLD), .reqB_out(reqB_out),
    .reqA_WR_GRANT(reqA_WR_GRANT), .reqA_WR_RDY(reqA_WR_RDY),
    .reqB_WR_GRANT(reqB_WR_GRANT), .reqB_WR_RDY(reqB_WR_RDY),
    .pxMem_WR_REQ(pxMem_WR_REQ), .pxMem_WR_Addr(pxMem_WR_Addr), .pxMem_WR_burst(pxMem_WR_burst),
    .pxMem_WR_VLD(pxMem_WR_VLD), .pxMem_out(pxMem_out),
    .pxMem_WR_GRANT(pxMem_WR_GRANT), .pxMem_WR_RDY(pxMem_WR_RDY),
    .wr_busy(wr_busy)
  );

  assign allOuts = {pxMem_WR_REQ, pxMem_WR_Addr, pxMem_WR_burst, pxMem_WR_VLD, pxMem_out,
                    reqA_WR_GRANT, reqB_WR_GRANT, reqA_WR_RDY, reqB_WR_RDY, wr_busy};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory command side: grant after grantDelay cycles of REQ
  int reqCycles = 0;
  always @(posedge clk) begin
    #1;
    if (pxMem_WR_REQ) begin
      pxMem_WR_GRANT = (reqCycles >= grantDelay);
      reqCycles++;
    end else begin
      pxMem_WR_GRANT = 1'b0;
      reqCycles = 0;
    end
  end

  // Write log: each accepted word at burst start address + beat index
  logic  prevReq = 1'b0;
  int    mIdx = 0;
  wrRecT rec;
  always @(negedge clk) begin
    if (pxMem_WR_REQ && !prevReq) reqRise.push_back(cyc);
    prevReq = pxMem_WR_REQ;
    if (pxMem_WR_REQ) mIdx = 0;
    if (pxMem_WR_VLD && pxMem_WR_RDY) begin
      rec.addr = pxMem_WR_Addr + 20'(mIdx);
      rec.data = pxMem_out;
      rec.isB  = reqB_WR_GRANT;
      rec.cyc  = cyc;
      writes.push_back(rec);
      mIdx++;
    end
  end

  // Producer A: data = base + word index; optional 1,0,0 valid pattern in XFER
  logic aBeat;
  int   aIdx = 0, aPh = 0;
  always begin
    @(negedge clk);
    aBeat = reqA_WR_VLD && reqA_WR_RDY;
    @(posedge clk);
    #1;
    if (!reqA_WR_GRANT) aIdx = 0;
    else if (aBeat) aIdx++;
    if (reqA_WR_RDY) begin
      reqA_WR_VLD = aEn && (!aGap || (aPh % 3 == 0));
      aPh++;
    end else begin
      reqA_WR_VLD = aEn;
      aPh = 0;
    end
    reqA_out = aBase + 16'(aIdx);
  end

  // Producer B: valid whenever enabled, so anything it offers while not owner must be dropped
  logic bBeat;
  int   bIdx = 0;
  always begin
    @(negedge clk);
    bBeat = reqB_WR_VLD && reqB_WR_RDY;
    @(posedge clk);
    #1;
    if (!reqB_WR_GRANT) bIdx = 0;
    else if (bBeat) bIdx++;
    reqB_WR_VLD = bEn;
    reqB_out = bBase + 16'(bIdx);
  end

  task automatic doReset();
    rst_n = 1'b0;
    reqA_WR_REQ = 1'b0; reqB_WR_REQ = 1'b0;
    reqA_WR_Addr = '0; reqB_WR_Addr = '0;
    reqA_WR_burst = '0; reqB_WR_burst = '0;
    aEn = 1'b0; bEn = 1'b0; aGap = 1'b0; aBase = '0; bBase = '0;
    grantDelay = 1; pxMem_WR_RDY = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    reqA_WR_REQ = 1'b1; reqB_WR_REQ = 1'b1; aEn = 1'b1; bEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (allOuts !== '0) begin
      nErrors++; $display("FAIL reset_hold: outputs=%h expected 0", allOuts);
    end
    reqA_WR_REQ = 1'b0; reqB_WR_REQ = 1'b0; aEn = 1'b0; bEn = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (allOuts !== '0) begin
      nErrors++; $display("FAIL reset_idle: outputs=%h expected 0", allOuts);
    end
  endtask

  task automatic test_single();
    logic [5:0] gotReq, gotGnt, gotBusy;
    int w0;
    doReset();
    w0 = writes.size();
    @(posedge clk); #1;
    reqA_WR_REQ = 1'b1; reqA_WR_Addr = 20'h00010; reqA_WR_burst = 4'd0; aBase = 16'hBEEF; aEn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      gotReq[c] = pxMem_WR_REQ; gotGnt[c] = reqA_WR_GRANT; gotBusy[c] = wr_busy;
      @(posedge clk); #1;
      if (reqA_WR_GRANT) reqA_WR_REQ = 1'b0;
    end
    aEn = 1'b0;
    nChecks++;
    if (gotReq !== 6'b000110) begin
      nErrors++; $display("FAIL single_memreq: cycles=%b expected 000110", gotReq);
    end
    nChecks++;
    if (gotGnt !== 6'b001110) begin
      nErrors++; $display("FAIL single_grantA: cycles=%b expected 001110", gotGnt);
    end
    nChecks++;
    if (gotBusy !== 6'b001110) begin
      nErrors++; $display("FAIL single_busy: cycles=%b expected 001110", gotBusy);
    end
    nChecks++;
    if (writes.size() - w0 != 1 || writes[w0].addr !== 20'h00010 || writes[w0].data !== 16'hBEEF) begin
      nErrors++; $display("FAIL single_write: count=%0d expected 1 word 0xBEEF at 0x00010", writes.size() - w0);
    end
  endtask

  task automatic test_tie();
    int w0, r0, c0, n;
    bit done;
    logic [19:0] eA;
    logic [15:0] eD;
    doReset();
    w0 = writes.size(); r0 = reqRise.size();
    @(posedge clk); #1;
    c0 = cyc;
    reqA_WR_REQ = 1'b1; reqA_WR_Addr = 20'h00100; reqA_WR_burst = 4'd3; aBase = 16'hA000; aEn = 1'b1;
    reqB_WR_REQ = 1'b1; reqB_WR_Addr = 20'h00200; reqB_WR_burst = 4'd1; bBase = 16'hB000; bEn = 1'b1;
    done = 1'b0;
    for (int c = 1; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      if (reqA_WR_GRANT) reqA_WR_REQ = 1'b0;
      if (reqB_WR_GRANT) reqB_WR_REQ = 1'b0;
      if (writes.size() - w0 >= 6 && !wr_busy) done = 1'b1;
    end
    aEn = 1'b0; bEn = 1'b0;
    n = writes.size() - w0;
    nChecks++;
    if (!done || n != 6) begin
      nErrors++; $display("FAIL tie_count: words=%0d done=%0d expected 6 words", n, done);
    end
    for (int i = 0; i < 6 && i < n; i++) begin
      eA = (i < 4) ? 20'h00100 + 20'(i) : 20'h00200 + 20'(i - 4);
      eD = (i < 4) ? 16'hA000 + 16'(i) : 16'hB000 + 16'(i - 4);
      nChecks++;
      if (writes[w0+i].addr !== eA || writes[w0+i].data !== eD || writes[w0+i].isB !== (i >= 4)) begin
        nErrors++;
        $display("FAIL tie_word[%0d]: addr=%h data=%h B=%0d expected addr=%h data=%h B=%0d",
                 i, writes[w0+i].addr, writes[w0+i].data, writes[w0+i].isB, eA, eD, (i >= 4));
      end
    end
    nChecks++;
    if (reqRise.size() - r0 != 2 || reqRise[r0] != c0 + 1 || reqRise[r0+1] != c0 + 8) begin
      nErrors++; $display("FAIL tie_req_timing: rises=%0d expected memreq rises in cycles 1 and 8", reqRise.size() - r0);
    end
  endtask

  task automatic test_alternate();
    int w0, r0, c0, n, aGrants;
    bit done, prevGnt;
    logic [19:0] eA;
    logic [15:0] eD;
    logic        eB;
    doReset();
    w0 = writes.size(); r0 = reqRise.size();
    @(posedge clk); #1;
    c0 = cyc;
    reqA_WR_REQ = 1'b1; reqA_WR_Addr = 20'h00300; reqA_WR_burst = 4'd1; aBase = 16'hA000; aEn = 1'b1;
    reqB_WR_Addr = 20'h00400; reqB_WR_burst = 4'd2; bBase = 16'hB000; bEn = 1'b1;
    done = 1'b0; aGrants = 0; prevGnt = 1'b0;
    for (int c = 1; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      if (c == 2) reqB_WR_REQ = 1'b1;
      if (reqB_WR_GRANT) reqB_WR_REQ = 1'b0;
      if (reqA_WR_GRANT && !prevGnt) aGrants++;
      prevGnt = reqA_WR_GRANT;
      if (aGrants >= 2) reqA_WR_REQ = 1'b0;
      if (writes.size() - w0 >= 7 && !wr_busy) done = 1'b1;
    end
    aEn = 1'b0; bEn = 1'b0;
    n = writes.size() - w0;
    nChecks++;
    if (!done || n != 7) begin
      nErrors++; $display("FAIL alt_count: words=%0d done=%0d expected 7 words", n, done);
    end
    for (int i = 0; i < 7 && i < n; i++) begin
      eB = (i >= 2 && i < 5);
      eA = eB ? 20'h00400 + 20'(i - 2) : 20'h00300 + 20'(i % 5);
      eD = eB ? 16'hB000 + 16'(i - 2) : 16'hA000 + 16'(i % 5);
      nChecks++;
      if (writes[w0+i].addr !== eA || writes[w0+i].data !== eD || writes[w0+i].isB !== eB) begin
        nErrors++;
        $display("FAIL alt_word[%0d]: addr=%h data=%h B=%0d expected addr=%h data=%h B=%0d",
                 i, writes[w0+i].addr, writes[w0+i].data, writes[w0+i].isB, eA, eD, eB);
      end
    end
    nChecks++;
    if (reqRise.size() - r0 != 3 || reqRise[r0] != c0 + 1 || reqRise[r0+1] != c0 + 6 || reqRise[r0+2] != c0 + 12) begin
      nErrors++; $display("FAIL alt_req_gaps: rises=%0d expected memreq rises in cycles 1, 6, 12", reqRise.size() - r0);
    end
  endtask

  task automatic test_vld_gaps();
    int w0, c0, n, idleCyc;
    doReset();
    w0 = writes.size();
    @(posedge clk); #1;
    c0 = cyc;
    reqA_WR_REQ = 1'b1; reqA_WR_Addr = 20'h00500; reqA_WR_burst = 4'd15; aBase = 16'hC000; aEn = 1'b1; aGap = 1'b1;
    idleCyc = -1;
    for (int c = 1; c < 150 && idleCyc < 0; c++) begin
      @(posedge clk); #1;
      if (reqA_WR_GRANT) reqA_WR_REQ = 1'b0;
      if (!wr_busy) idleCyc = c;
    end
    aEn = 1'b0; aGap = 1'b0;
    n = writes.size() - w0;
    nChecks++;
    if (n != 16) begin
      nErrors++; $display("FAIL gaps_count: words=%0d expected 16", n);
    end
    for (int i = 0; i < 16 && i < n; i++) begin
      nChecks++;
      if (writes[w0+i].addr !== 20'h00500 + 20'(i) || writes[w0+i].data !== 16'hC000 + 16'(i)) begin
        nErrors++;
        $display("FAIL gaps_word[%0d]: addr=%h data=%h expected addr=%h data=%h",
                 i, writes[w0+i].addr, writes[w0+i].data, 20'h00500 + 20'(i), 16'hC000 + 16'(i));
      end
    end
    nChecks++;
    if (n < 16 || writes[w0+15].cyc != c0 + 48) begin
      nErrors++; $display("FAIL gaps_last_beat: cycle=%0d expected 48", (n >= 16) ? writes[w0+15].cyc - c0 : -1);
    end
    nChecks++;
    if (idleCyc != 49) begin
      nErrors++; $display("FAIL gaps_idle: idle in cycle %0d expected 49", idleCyc);
    end
  endtask

  task automatic test_read_block();
    int w0, n;
    bit done;
    doReset();
    w0 = writes.size();
    grantDelay = 20;
    @(posedge clk); #1;
    reqA_WR_REQ = 1'b1; reqA_WR_Addr = 20'h00600; reqA_WR_burst = 4'd2; aBase = 16'hD000; aEn = 1'b1;
    done = 1'b0;
    for (int c = 1; c < 80 && !done; c++) begin
      @(posedge clk); #1;
      if (c <= 21) begin
        nChecks++;
        if (pxMem_WR_REQ !== 1'b1 || pxMem_WR_Addr !== 20'h00600 || pxMem_WR_burst !== 4'd2 || reqA_WR_RDY !== 1'b0) begin
          nErrors++;
          $display("FAIL blocked_hold[%0d]: req=%b addr=%h burst=%h rdy=%b expected 1 00600 2 0",
                   c, pxMem_WR_REQ, pxMem_WR_Addr, pxMem_WR_burst, reqA_WR_RDY);
        end
      end
      if (c == 22) begin
        nChecks++;
        if (pxMem_WR_REQ !== 1'b0 || reqA_WR_RDY !== 1'b1) begin
          nErrors++; $display("FAIL blocked_xfer_entry: req=%b rdy=%b expected 0 1", pxMem_WR_REQ, reqA_WR_RDY);
        end
      end
      if (reqA_WR_GRANT) reqA_WR_REQ = 1'b0;
      if (c > 22 && !wr_busy) done = 1'b1;
    end
    aEn = 1'b0; grantDelay = 1;
    n = writes.size() - w0;
    nChecks++;
    if (!done || n != 3 || writes[w0].addr !== 20'h00600 || writes[w0+2].addr !== 20'h00602 || writes[w0+2].data !== 16'hD002) begin
      nErrors++; $display("FAIL blocked_words: words=%0d done=%0d expected 3 words at 0x00600", n, done);
    end
  endtask

  task automatic test_reset_mid();
    int w0, w1, n;
    bit done;
    doReset();
    w0 = writes.size();
    @(posedge clk); #1;
    reqA_WR_REQ = 1'b1; reqA_WR_Addr = 20'h00700; reqA_WR_burst = 4'd7; aBase = 16'hE000; aEn = 1'b1;
    done = 1'b0;
    for (int c = 1; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (reqA_WR_GRANT) reqA_WR_REQ = 1'b0;
      if (writes.size() - w0 >= 3) done = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    nChecks++;
    if (!done || allOuts !== '0) begin
      nErrors++; $display("FAIL midreset_outputs: outputs=%h started=%0d expected 0", allOuts, done);
    end
    aEn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nChecks++;
    if (writes.size() - w0 != 3) begin
      nErrors++; $display("FAIL midreset_words: words=%0d expected 3", writes.size() - w0);
    end
    w1 = writes.size();
    @(posedge clk); #1;
    reqA_WR_REQ = 1'b1; reqA_WR_Addr = 20'h00800; reqA_WR_burst = 4'd0; aBase = 16'hA100; aEn = 1'b1;
    reqB_WR_REQ = 1'b1; reqB_WR_Addr = 20'h00900; reqB_WR_burst = 4'd0; bBase = 16'hB100; bEn = 1'b1;
    done = 1'b0;
    for (int c = 1; c < 60 && !done; c++) begin
      @(posedge clk); #1;
      if (reqA_WR_GRANT) reqA_WR_REQ = 1'b0;
      if (reqB_WR_GRANT) reqB_WR_REQ = 1'b0;
      if (writes.size() - w1 >= 2 && !wr_busy) done = 1'b1;
    end
    aEn = 1'b0; bEn = 1'b0;
    n = writes.size() - w1;
    nChecks++;
    if (!done || n != 2 || writes[w1].isB !== 1'b0 || writes[w1].addr !== 20'h00800 || writes[w1].data !== 16'hA100
        || writes[w1+1].isB !== 1'b1 || writes[w1+1].addr !== 20'h00900) begin
      nErrors++; $display("FAIL midreset_tie: words=%0d first_owner_B=%0d expected A first then B", n, (n > 0) ? writes[w1].isB : 1'bx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_alternate();
    test_vld_gaps();
    test_read_block();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
